lcd_rx: RTL

LCD_RX -- requirements
Module: lcd_rx

---
 rtl/lcd_pkg.sv | 29 ++
 rtl/lcd_sync.sv | 51 +++++
 rtl/lcd_rx.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 bus receiver.
package lcd_pkg;

    typedef enum logic [1:0] {MODE8, NIB_HI, NIB_LO} state_e;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam logic [3:0] FUNC_4BIT     = 4'h2;

    localparam logic [6:0] WRAP_ROW0 = 7'h27;
    localparam logic [6:0] WRAP_ROW1 = 7'h67;
    localparam logic [6:0] ROW1_BASE = 7'h40;

    // Two-line DDRAM walk: row 0 ends at 0x27, row 1 ends at 0x67.
    function automatic logic [6:0] cursor_next(input logic [6:0] a);
        if (a >= WRAP_ROW1)
            return 7'h00;
        else if (a >= WRAP_ROW0 && a < ROW1_BASE)
            return ROW1_BASE;
        else
            return a + 7'd1;
    endfunction

    function automatic logic cursor_visible(input logic [6:0] a);
        return (a[5:4] == 2'b00);
    endfunction

endpackage

// File: rtl/lcd_sync.sv
// Two-flop synchroniser for the LCD bus plus a registered falling-edge
// detector on lcd_e that captures rs/rw/dat alongside the strobe.
module lcd_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       e_i,
    input  logic       rs_i,
    input  logic       rw_i,
    input  logic [3:0] dat_i,
    output logic       fall_o,
    output logic       rs_o,
    output logic       rw_o,
    output logic [3:0] dat_o
);

    logic [6:0] s1_q, s2_q;
    logic       e_prev_q;
    logic       fall_q, rs_q, rw_q;
    logic [3:0] dat_q;
    logic       fall;

    assign fall = e_prev_q & ~s2_q[6];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            e_prev_q <= 1'b0;
            fall_q   <= 1'b0;
            rs_q     <= 1'b0;
            rw_q     <= 1'b0;
            dat_q    <= 4'h0;
        end else begin
            s1_q     <= {e_i, rs_i, rw_i, dat_i};
            s2_q     <= s1_q;
            e_prev_q <= s2_q[6];
            fall_q   <= fall;
            if (fall) begin
                rs_q  <= s2_q[5];
                rw_q  <= s2_q[4];
                dat_q <= s2_q[3:0];
            end
        end
    end

    assign fall_o = fall_q;
    assign rs_o   = rs_q;
    assign rw_o   = rw_q;
    assign dat_o  = dat_q;

endmodule

// File: rtl/lcd_rx.sv
// HD44780 write-bus sniffer: reassembles bytes, tracks the DDRAM cursor
// and reports writes to the 2x16 visible window.
module lcd_rx
    import lcd_pkg::*;
#(
    parameter int TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [3:0] lcd_dat,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_rs,
    output logic       wr_en,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       clr,
    output logic       mode4,
    output logic       err
);

    logic       fall, s_rs, s_rw;
    logic [3:0] s_dat;

    lcd_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .e_i    (lcd_e),
        .rs_i   (lcd_rs),
        .rw_i   (lcd_rw),
        .dat_i  (lcd_dat),
        .fall_o (fall),
        .rs_o   (s_rs),
        .rw_o   (s_rw),
        .dat_o  (s_dat)
    );

    state_e      state_q, state_d;
    logic [3:0]  hi_q, hi_d;
    logic        hrs_q, hrs_d;
    logic [16:0] cnt_q, cnt_d;
    logic        mode4_q, mode4_d, err_q, err_d;
    logic        asm_valid_q, asm_valid_d, asm_rs_q, asm_rs_d;
    logic [7:0]  asm_byte_q, asm_byte_d;
    logic        wr_strobe;

    assign wr_strobe = fall & ~s_rw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= MODE8;
            hi_q        <= 4'h0;
            hrs_q       <= 1'b0;
            cnt_q       <= '0;
            mode4_q     <= 1'b0;
            err_q       <= 1'b0;
            asm_valid_q <= 1'b0;
            asm_rs_q    <= 1'b0;
            asm_byte_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            hrs_q       <= hrs_d;
            cnt_q       <= cnt_d;
            mode4_q     <= mode4_d;
            err_q       <= err_d;
            asm_valid_q <= asm_valid_d;
            asm_rs_q    <= asm_rs_d;
            asm_byte_q  <= asm_byte_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        hrs_d       = hrs_q;
        cnt_d       = cnt_q;
        mode4_d     = mode4_q;
        err_d       = err_q;
        asm_valid_d = 1'b0;
        asm_rs_d    = asm_rs_q;
        asm_byte_d  = asm_byte_q;
        if (fall && s_rw)
            err_d = 1'b1;
        unique case (state_q)
            MODE8: begin
                if (wr_strobe) begin
                    asm_valid_d = 1'b1;
                    asm_byte_d  = {s_dat, 4'h0};
                    asm_rs_d    = s_rs;
                    if (s_dat == FUNC_4BIT) begin
                        state_d = NIB_HI;
                        mode4_d = 1'b1;
                    end
                end
            end
            NIB_HI: begin
                cnt_d = '0;
                if (wr_strobe) begin
                    hi_d    = s_dat;
                    hrs_d   = s_rs;
                    state_d = NIB_LO;
                end
            end
            NIB_LO: begin
                if (wr_strobe) begin
                    asm_valid_d = 1'b1;
                    asm_byte_d  = {hi_q, s_dat};
                    asm_rs_d    = hrs_q;
                    state_d     = NIB_HI;
                    cnt_d       = '0;
                end else if (cnt_q >= 17'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = NIB_HI;
                    cnt_d   = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 17'd1;
                end
            end
            default: state_d = MODE8;
        endcase
    end

    logic [6:0] cursor_q, cursor_d;
    logic       bv_q, bv_d, brs_q, brs_d;
    logic [7:0] bdat_q, bdat_d, wdat_q, wdat_d;
    logic       wen_q, wen_d, clr_q, clr_d;
    logic [4:0] waddr_q, waddr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cursor_q <= 7'h00;
            bv_q     <= 1'b0;
            brs_q    <= 1'b0;
            bdat_q   <= 8'h00;
            wdat_q   <= 8'h00;
            wen_q    <= 1'b0;
            clr_q    <= 1'b0;
            waddr_q  <= 5'd0;
        end else begin
            cursor_q <= cursor_d;
            bv_q     <= bv_d;
            brs_q    <= brs_d;
            bdat_q   <= bdat_d;
            wdat_q   <= wdat_d;
            wen_q    <= wen_d;
            clr_q    <= clr_d;
            waddr_q  <= waddr_d;
        end
    end

    always_comb begin
        cursor_d = cursor_q;
        bv_d     = 1'b0;
        brs_d    = brs_q;
        bdat_d   = bdat_q;
        wdat_d   = wdat_q;
        wen_d    = 1'b0;
        clr_d    = 1'b0;
        waddr_d  = waddr_q;
        if (asm_valid_q) begin
            bv_d   = 1'b1;
            bdat_d = asm_byte_q;
            brs_d  = asm_rs_q;
            if (asm_rs_q) begin
                if (cursor_visible(cursor_q)) begin
                    wen_d   = 1'b1;
                    waddr_d = {cursor_q[6], cursor_q[3:0]};
                    wdat_d  = asm_byte_q;
                end
                cursor_d = cursor_next(cursor_q);
            end else if (asm_byte_q == CMD_CLEAR) begin
                clr_d    = 1'b1;
                cursor_d = 7'h00;
            end else if (asm_byte_q[7:1] == CMD_HOME[7:1]) begin
                cursor_d = 7'h00;
            end else if ((asm_byte_q & CMD_SET_DDRAM) != 8'h00) begin
                cursor_d = asm_byte_q[6:0];
            end
        end
    end

    assign byte_valid = bv_q;
    assign byte_data  = bdat_q;
    assign byte_rs    = brs_q;
    assign wr_en      = wen_q;
    assign wr_addr    = waddr_q;
    assign wr_data    = wdat_q;
    assign clr        = clr_q;
    assign mode4      = mode4_q;
    assign err        = err_q;

endmodule
